// File: rtl/iter_mult_unit.sv
// iter_mult_unit: multi-cycle radix-2^BITS_PER_CYCLE shift-add multiplier for
// the EX stage. Returns the low DATA_W bits of op_a*op_b together with the
// latched destination register and a register-file write strobe.
module iter_mult_unit #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        waddr_in,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        waddr_out,
    output logic              reg_write_out
);

    localparam int unsigned N_ITER = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_count;
    logic [4:0]          r_waddr_pend;
    logic [DATA_W-1:0]   r_result;
    logic [4:0]          r_waddr_out;

    logic                w_accept;
    logic                w_last;
    logic [DATA_W-1:0]   w_pp;
    logic [DATA_W-1:0]   w_acc_nxt;

    // A new multiply is taken only from IDLE or DONE; flush blocks it.
    assign w_accept  = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_count == CNT_W'(N_ITER - 1));
    assign w_pp      = r_mcand * DATA_W'(r_mplier[BITS_PER_CYCLE-1:0]);
    assign w_acc_nxt = r_acc + w_pp;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; flush returns to IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (flush)       w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept) w_state_nxt = S_BUSY;
                else          w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result/destination hold.
    // The destination is kept in a pending register until completion so that
    // waddr_out stays paired with result across a flushed or in-flight op.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_count      <= '0;
            r_waddr_pend <= '0;
            r_result     <= '0;
            r_waddr_out  <= '0;
        end else if (w_accept) begin
            r_mcand      <= op_a;
            r_mplier     <= op_b;
            r_waddr_pend <= waddr_in;
            r_acc        <= '0;
            r_count      <= '0;
        end else if ((r_state == S_BUSY) && !flush) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_count  <= r_count + CNT_W'(1);
            if (w_last) begin
                r_result    <= w_acc_nxt;
                r_waddr_out <= r_waddr_pend;
            end
        end
    end

    assign busy          = (r_state == S_BUSY);
    assign valid         = (r_state == S_DONE);
    assign result        = r_result;
    assign waddr_out     = r_waddr_out;
    assign reg_write_out = valid && (r_waddr_out != 5'd0);

endmodule

// File: tb/tb_iter_mult_unit.sv
// Scoreboard bench for iter_mult_unit: stimulus pushes expected completions,
// a negedge monitor pops and compares on every valid pulse.
module tb_iter_mult_unit;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BPC    = 4;
    localparam int unsigned N_ITER = DATA_W / BPC;

    logic              clk;
    logic              arst_n;
    logic              start;
    logic              flush;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        waddr_in;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [4:0]        waddr_out;
    logic              reg_write_out;

    typedef struct {
        logic [DATA_W-1:0] res;
        logic [4:0]        wa;
        logic              rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vcount   = 0;

    iter_mult_unit #(.DATA_W(DATA_W), .BITS_PER_CYCLE(BPC)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .start         (start),
        .flush         (flush),
        .op_a          (op_a),
        .op_b          (op_b),
        .waddr_in      (waddr_in),
        .busy          (busy),
        .valid         (valid),
        .result        (result),
        .waddr_out     (waddr_out),
        .reg_write_out (reg_write_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arst_n && valid) begin
            vcount++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: result=0x%0h waddr=%0d with empty scoreboard", result, waddr_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_result", 32'(result), 32'(e.res));
                chk("sb_waddr", 32'(waddr_out), 32'(e.wa));
                chk("sb_reg_write", 32'(reg_write_out), 32'(e.rw));
            end
        end
    end

    // Issue a multiply at the current cycle; optionally expect its completion.
    task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [4:0] w, input logic [DATA_W-1:0] exp, input bit push);
        exp_t e;
        op_a = a; op_b = b; waddr_in = w; start = 1'b1;
        if (push) begin
            e.res = exp; e.wa = w; e.rw = (w != 5'd0);
            exp_q.push_back(e);
        end
        step();
        start = 1'b0;
        op_a = DATA_W'($urandom);
        op_b = DATA_W'($urandom);
        waddr_in = 5'($urandom);
    endtask

    // Full op: busy for exactly N_ITER cycles, then valid (checked by monitor).
    task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [4:0] w, input logic [DATA_W-1:0] exp);
        issue(a, b, w, exp, 1'b1);
        for (int i = 0; i < int'(N_ITER); i++) begin
            chk("busy_during_iter", 32'(busy), 32'd1);
            step();
        end
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("valid_at_done", 32'(valid), 32'd1);
    endtask

    initial begin
        int vc;
        arst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; waddr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_waddr", 32'(waddr_out), 32'd0);
        chk("rst_reg_write", 32'(reg_write_out), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        step();

        // Basic 3*5, then result holds after valid drops.
        run_op(16'd3, 16'd5, 5'd7, 16'h000F);
        step();
        chk("post_done_valid", 32'(valid), 32'd0);
        chk("post_done_reg_write", 32'(reg_write_out), 32'd0);
        chk("post_done_result", 32'(result), 32'h000F);
        chk("post_done_waddr", 32'(waddr_out), 32'd7);

        // Wrap and shift.
        run_op(16'hFFFF, 16'hFFFF, 5'd3, 16'h0001);
        step();
        run_op(16'h1234, 16'h0010, 5'd4, 16'h2340);
        step();

        // Back-to-back: second start issued in the DONE cycle of the first.
        run_op(16'd3, 16'd5, 5'd5, 16'h000F);
        run_op(16'h0100, 16'h0100, 5'd6, 16'h0000);
        step();

        // x0 destination: valid pulses, no write strobe.
        run_op(16'd2, 16'd2, 5'd0, 16'h0004);
        step();

        // Flush in the second BUSY cycle of 7*9.
        vc = vcount;
        issue(16'd7, 16'd9, 5'd8, 16'd63, 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(valid), 32'd0);
        repeat (6) step();
        chk("flush_no_valid", 32'(vcount - vc), 32'd0);
        chk("flush_result_kept", 32'(result), 32'h0004);
        chk("flush_waddr_kept", 32'(waddr_out), 32'd0);

        // flush and start together from IDLE: not accepted.
        flush = 1'b1; start = 1'b1;
        op_a = 16'd1; op_b = 16'd1; waddr_in = 5'd9;
        step();
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        chk("flush_start_valid", 32'(valid), 32'd0);
        step();

        // Async reset during the third BUSY cycle.
        issue(16'd5, 16'd5, 5'd9, 16'd25, 1'b0);
        step();
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_reg_write", 32'(reg_write_out), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        step();
        run_op(16'd6, 16'd7, 5'd10, 16'h002A);
        repeat (3) step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
